// File: rtl/decode_issue_stage.sv
// Single-entry decode/issue stage: latches one fetched instruction, decodes ADD/ADDI/MUL,
// reads operands, tracks in-flight destinations in a scoreboard and issues in order.
module decode_issue_stage #(
  parameter logic [2:0] p_tinyrv1    = 3'b111,
  parameter logic [2:0] p_isa_subset = p_tinyrv1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] F_inst,
  input  logic [31:0] F_pc,
  input  logic        F_val,
  output logic        F_rdy,

  output logic [4:0]  rf_raddr0,
  output logic [4:0]  rf_raddr1,
  input  logic [31:0] rf_rdata0,
  input  logic [31:0] rf_rdata1,

  output logic [1:0]  X_uop,
  output logic [31:0] X_pc,
  output logic [31:0] X_op1,
  output logic [31:0] X_op2,
  output logic [4:0]  X_waddr,
  output logic        X_wen,
  output logic        X_val,
  input  logic        X_rdy,

  input  logic [4:0]  C_waddr,
  input  logic        C_wen,

  output logic        illegal
);

  localparam int OP_ADD_VEC  = 0;
  localparam int OP_ADDI_VEC = 1;
  localparam int OP_MUL_VEC  = 2;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_ADD    = 3'b000;

  logic        d_val;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [31:0] sb;
  logic [31:0] sb_next;

  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm_i;

  logic [1:0]  dec_uop;
  logic        dec_legal;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        dec_wen;
  logic        dec_op2_imm;

  logic        stall;
  logic        issue_fire;
  logic        drop;
  logic        fetch_load;
  logic        haz_rs1;
  logic        haz_rs2;
  logic        haz_rd;

  assign dec_opcode = d_inst[6:0];
  assign dec_rd     = d_inst[11:7];
  assign dec_funct3 = d_inst[14:12];
  assign dec_rs1    = d_inst[19:15];
  assign dec_rs2    = d_inst[24:20];
  assign dec_funct7 = d_inst[31:25];
  assign dec_imm_i  = {{20{d_inst[31]}}, d_inst[31:20]};

  // ADDI is issued as an ADD uop with the immediate selected for operand 2.
  always_comb begin
    dec_uop      = OP_NOP;
    dec_legal    = 1'b0;
    dec_uses_rs1 = 1'b0;
    dec_uses_rs2 = 1'b0;
    dec_wen      = 1'b0;
    dec_op2_imm  = 1'b0;
    if (dec_opcode == OPC_REG && dec_funct3 == F3_ADD) begin
      if (dec_funct7 == F7_BASE && p_isa_subset[OP_ADD_VEC]) begin
        dec_uop      = OP_ADD;
        dec_legal    = 1'b1;
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        dec_wen      = 1'b1;
      end else if (dec_funct7 == F7_MULDIV && p_isa_subset[OP_MUL_VEC]) begin
        dec_uop      = OP_MUL;
        dec_legal    = 1'b1;
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        dec_wen      = 1'b1;
      end
    end else if (dec_opcode == OPC_IMM && dec_funct3 == F3_ADD
                 && p_isa_subset[OP_ADDI_VEC]) begin
      dec_uop      = OP_ADD;
      dec_legal    = 1'b1;
      dec_uses_rs1 = 1'b1;
      dec_wen      = 1'b1;
      dec_op2_imm  = 1'b1;
    end
  end

  assign rf_raddr0 = dec_rs1;
  assign rf_raddr1 = dec_rs2;

  // Hazards look only at registered scoreboard bits, so completions never reach X_val combinationally.
  assign haz_rs1 = dec_uses_rs1 && (dec_rs1 != 5'd0) && sb[dec_rs1];
  assign haz_rs2 = dec_uses_rs2 && (dec_rs2 != 5'd0) && sb[dec_rs2];
  assign haz_rd  = dec_wen      && (dec_rd  != 5'd0) && sb[dec_rd];
  assign stall   = haz_rs1 || haz_rs2 || haz_rd;

  assign X_val      = d_val && dec_legal && !stall;
  assign issue_fire = X_val && X_rdy;
  assign drop       = d_val && !dec_legal;
  assign illegal    = drop;
  assign F_rdy      = !d_val || issue_fire || drop;
  assign fetch_load = F_val && F_rdy;

  assign X_uop   = dec_uop;
  assign X_pc    = d_pc;
  assign X_waddr = dec_rd;
  assign X_wen   = d_val && dec_legal && dec_wen && (dec_rd != 5'd0);
  assign X_op1   = (dec_rs1 == 5'd0) ? 32'd0 : rf_rdata0;

  always_comb begin
    if (dec_op2_imm) begin
      X_op2 = dec_imm_i;
    end else if (dec_rs2 == 5'd0) begin
      X_op2 = 32'd0;
    end else begin
      X_op2 = rf_rdata1;
    end
  end

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    sb_next = sb;
    if (C_wen && C_waddr != 5'd0) begin
      sb_next[C_waddr] = 1'b0;
    end
    if (issue_fire && X_wen) begin
      sb_next[dec_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_val  <= 1'b0;
      d_inst <= 32'd0;
      d_pc   <= 32'd0;
      sb     <= 32'd0;
    end else begin
      sb <= sb_next;
      if (fetch_load) begin
        d_val  <= 1'b1;
        d_inst <= F_inst;
        d_pc   <= F_pc;
      end else if (issue_fire || drop) begin
        d_val  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Single-entry decode/issue pipeline stage between fetch and the execute units.
- Latches one fetched instruction and decodes it for the configured ISA subset (ADD, ADDI, MUL).
- Reads operands from the external register file and tracks in-flight destination registers in a 32-bit scoreboard.
- Issues one micro-op per cycle in order to execute over a val/rdy handshake, stalling on RAW/WAW hazards.

Parameters:
- p_isa_subset, default p_tinyrv1: opcode-enable vector. Only uops whose OP_*_VEC bit is set decode as legal.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- F_inst  in  32  fetched instruction
- F_pc  in  32  PC of fetched instruction
- F_val  in  1  fetch data valid
- F_rdy  out  1  stage can accept an instruction
- rf_raddr0  out  5  regfile read address 0 (rs1)
- rf_raddr1  out  5  regfile read address 1 (rs2)
- rf_rdata0  in  32  combinational read data 0
- rf_rdata1  in  32  combinational read data 1
- X_uop  out  rv_uop  issued micro-op
- X_pc  out  32  PC of issued instruction
- X_op1  out  32  operand 1
- X_op2  out  32  operand 2 (register or immediate)
- X_waddr  out  5  destination register
- X_wen  out  1  destination write enable
- X_val  out  1  issue valid
- X_rdy  in  1  execute can accept
- C_waddr  in  5  completing (written-back) register
- C_wen  in  1  completion valid; clears scoreboard bit
- illegal  out  1  one-cycle pulse when an undecodable instruction is dropped

Behaviour:
- Reset is asynchronous and active-high. Clock and reset ports are clk and rst.
- Reset values: d_val=0, scoreboard=0, illegal=0.
  - Resulting outputs: X_val=0, F_rdy=1, X_wen=0.
  - Data outputs are don't-care while X_val=0.
- State: d_val, d_inst[31:0], d_pc[31:0], scoreboard sb[31:0].
- Fetch accept: F_rdy = !d_val || issue_fire || drop. On F_val && F_rdy, load d_inst and d_pc and set d_val=1 at the next edge.
- Latency: one cycle from fetch acceptance to earliest X_val.
- Decode is combinational from d_inst:
  - uop, raddr0, raddr1, waddr, wen, imm_sel, op2_sel.
  - legal = matched a subset-enabled pattern.
- Immediates: IMM_I = sign-extend d_inst[31:20] to 32 bits.
- Operands:
  - op1 = 0 if rs1==x0, else rf_rdata0.
  - op2 = imm if op2_sel=imm; 0 if rs2==x0; else rf_rdata1.
- Writes to x0: X_wen forced to 0; sb[0] is never set.
- Hazard:
  - stall = (uses rs1 && rs1!=0 && sb[rs1]) || (uses rs2 && rs2!=0 && sb[rs2]) || (wen && rd!=0 && sb[rd]).
  - ADDI does not use rs2.
- X_val = d_val && legal && !stall.
- issue_fire = X_val && X_rdy.
  - On issue_fire: if X_wen, set sb[rd]. d_val is cleared unless a new fetch loads the same edge (back-to-back, one instruction per cycle).
- Illegal instruction: drop = d_val && !legal. On drop, illegal=1 for that cycle, the entry is freed, and nothing issues.
- X_val holds with stable payload until X_rdy. X_val never drops without a handshake, except on rst.
- Scoreboard clear:
  - On C_wen, clear sb[C_waddr] at the next edge.
  - No bypass: a dependent instruction issues at the earliest one cycle after C_wen.
  - Combinational C_wen→X_val paths are forbidden.
- Simultaneous set and clear of the same register: set wins. This is unreachable under the WAW stall but still defined.
- C_wen with C_waddr==0 is ignored.
- rst mid-operation:
  - Pending instruction discarded, scoreboard cleared, outputs return to reset values asynchronously.
  - In-flight completions after reset are ignored if they target cleared bits (clearing is idempotent).

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) at F_pc=0x200 → next cycle X_val=1, X_uop=OP_ADD, X_op1=0, X_op2=5, X_waddr=1, X_wen=1, X_pc=0x200; sb[1]=1 after fire.
- ADD x3,x1,x2 immediately after ADDI x1 with X_rdy=1 → X_val=0 while sb[1]=1; C_wen=1, C_waddr=1 → X_val=1 the following cycle with op1=rf_rdata0.
- Back-to-back independent ADDI x1 / ADDI x2 / ADDI x4, X_rdy=1 → three consecutive issue cycles, F_rdy held 1.
- X_rdy=0 for 3 cycles with ADD x5,x6,x7 pending → X_val and payload stable, F_rdy=0; X_rdy=1 → single fire.
- Instruction 0xFFFFFFFF, or MUL with p_isa_subset lacking OP_MUL_VEC → illegal pulse for one cycle, no X_val, stage accepts the next instruction.
- ADDI x0,x0,1 → X_wen=0 and sb unchanged. Assert rst while an instruction is stalled → X_val=0 and sb=0 immediately.
